// File: rtl/fp_cmp_arb_if.sv
// Bus bundle for fp_cmp_arb: two requester ports, the shared comparator
// hookup and the response port. slave = arbiter side, master = environment.
interface fp_cmp_arb_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [63:0] req0_a;
    logic [63:0] req0_b;
    logic [1:0]  req0_op;
    logic        req1_valid;
    logic        req1_ready;
    logic [63:0] req1_a;
    logic [63:0] req1_b;
    logic [1:0]  req1_op;
    logic [63:0] cmp_a;
    logic [63:0] cmp_b;
    logic [1:0]  cmp_op;
    logic        cmp_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic        rsp_result;
    logic        rsp_nv;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output cmp_a, cmp_b, cmp_op,
        input  cmp_result,
        output rsp_valid, rsp_id, rsp_result, rsp_nv,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  cmp_a, cmp_b, cmp_op,
        output cmp_result,
        input  rsp_valid, rsp_id, rsp_result, rsp_nv,
        output rsp_ready
    );
endinterface

// File: rtl/fp_cmp_arb.sv
// fp_cmp_arb: round-robin arbiter in front of a shared combinational FP
// comparator. Stage 1 registers the granted operands (driven straight to the
// comparator), stage 2 registers the result for the consumer.
// Optional macro FP_CMP_ARB_NV_EN builds the IEEE invalid-operation flag;
// without it rsp_nv is tied to 0.
module fp_cmp_arb #(
    parameter bit PRIO_RST = 1'b0
) (
    input logic          clk,
    input logic          rst,
    fp_cmp_arb_if.slave  bus
);
    localparam logic [1:0] OP_EQ  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b01;

    logic        s1_valid;
    logic [63:0] s1_a;
    logic [63:0] s1_b;
    logic [1:0]  s1_op;
    logic        s1_id;
    logic        prio;
    logic        rsp_valid;
    logic        rsp_id;
    logic        rsp_result;

    logic        s2_adv;
    logic        s1_free;
    logic        any_req;
    logic        grant;
    logic        take;
    logic        a_nan;
    logic        b_nan;
    logic        force_zero;

    function automatic logic is_nan(input logic [63:0] x);
        return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
    endfunction

    // Handshake and grant decode; ready never depends on the other port's ready.
    always_comb begin
        s2_adv  = s1_valid && (!rsp_valid || bus.rsp_ready);
        s1_free = !s1_valid || s2_adv;
        any_req = bus.req0_valid || bus.req1_valid;
        grant   = (bus.req0_valid && bus.req1_valid) ? prio : bus.req1_valid;
        take    = s1_free && any_req && !rst;
    end

    assign bus.req0_ready = take && !grant;
    assign bus.req1_ready = take && grant;

    // NaN operands and the illegal op squash the comparator result.
    always_comb begin
        a_nan      = is_nan(s1_a);
        b_nan      = is_nan(s1_b);
        force_zero = (s1_op == OP_ILL) || a_nan || b_nan;
    end

    // Stage 1 operand register plus round-robin priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= 64'd0;
            s1_b     <= 64'd0;
            s1_op    <= 2'b00;
            s1_id    <= 1'b0;
            prio     <= PRIO_RST;
        end else if (take) begin
            s1_valid <= 1'b1;
            s1_a     <= grant ? bus.req1_a  : bus.req0_a;
            s1_b     <= grant ? bus.req1_b  : bus.req0_b;
            s1_op    <= grant ? bus.req1_op : bus.req0_op;
            s1_id    <= grant;
            prio     <= !grant;
        end else if (s2_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2 response register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= 1'b0;
        end else if (s2_adv) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= s1_id;
            rsp_result <= force_zero ? 1'b0 : bus.cmp_result;
        end else if (rsp_valid && bus.rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

`ifdef FP_CMP_ARB_NV_EN
    logic rsp_nv;
    logic nv_next;

    function automatic logic is_snan(input logic [63:0] x);
        return is_nan(x) && !x[51];
    endfunction

    // EQ only traps on signaling NaN; ordered compares trap on any NaN.
    always_comb begin
        nv_next = 1'b0;
        case (s1_op)
            OP_EQ:   nv_next = is_snan(s1_a) || is_snan(s1_b);
            OP_ILL:  nv_next = 1'b1;
            default: nv_next = a_nan || b_nan;
        endcase
    end

    // Invalid flag captured alongside the result.
    always_ff @(posedge clk) begin
        if (rst)
            rsp_nv <= 1'b0;
        else if (s2_adv)
            rsp_nv <= nv_next;
    end

    assign bus.rsp_nv = rsp_nv;
`else
    assign bus.rsp_nv = 1'b0;
`endif

    assign bus.cmp_a      = s1_a;
    assign bus.cmp_b      = s1_b;
    assign bus.cmp_op     = s1_op;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_id     = rsp_id;
    assign bus.rsp_result = rsp_result;
endmodule

// File: tb/tb_fp_cmp_arb.sv
// Scoreboard bench for fp_cmp_arb: accepts are logged with a reference-model
// result into a queue; an independent monitor pops and compares responses.
module tb_fp_cmp_arb;
    localparam bit PRIO = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_cmp_arb_if bus();

    fp_cmp_arb #(.PRIO_RST(PRIO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passed = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic logic nan(input logic [63:0] x);
        return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
    endfunction

    // External comparator: returns garbage (1) for NaN / illegal op so the
    // arbiter's squashing is observable.
    function automatic logic cmp_fn(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
        real ra, rb;
        if (op == 2'b01 || nan(a) || nan(b)) return 1'b1;
        ra = $bitstoreal(a);
        rb = $bitstoreal(b);
        case (op)
            2'b10:   return ra == rb;
            2'b11:   return ra <  rb;
            default: return ra <= rb;
        endcase
    endfunction

    assign bus.cmp_result = cmp_fn(bus.cmp_a, bus.cmp_b, bus.cmp_op);

    // Reference: {id, result, nv} straight from the IEEE rules.
    function automatic logic [2:0] model(input logic id, input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
        real ra, rb;
        logic res, nv, na, nb;
        na  = nan(a);
        nb  = nan(b);
        ra  = $bitstoreal(a);
        rb  = $bitstoreal(b);
        res = 1'b0;
        nv  = 1'b0;
        if (op != 2'b01 && !na && !nb) begin
            if (op == 2'b10)      res = (ra == rb);
            else if (op == 2'b11) res = (ra <  rb);
            else                  res = (ra <= rb);
        end
`ifdef FP_CMP_ARB_NV_EN
        if (op == 2'b01)      nv = 1'b1;
        else if (op == 2'b10) nv = (na && !a[51]) || (nb && !b[51]);
        else                  nv = na || nb;
`endif
        return {id, res, nv};
    endfunction

    logic [2:0] exp_q[$];
    logic       holder;
    int         inflight = 0;
    int         acc_cnt = 0;
    logic       g;

    // Accept logger: predicts ready/grant and pushes expected responses.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
            holder   = PRIO;
            inflight = 0;
            exp_q.delete();
        end else begin
            chk("ready_any", bus.req0_ready || bus.req1_ready,
                (bus.req0_valid || bus.req1_valid) && (inflight < 2 || bus.rsp_ready));
            if (bus.req0_ready || bus.req1_ready) begin
                g = (bus.req0_valid && bus.req1_valid) ? holder : bus.req1_valid;
                chk("grant", {bus.req1_ready, bus.req0_ready}, g ? 2'b10 : 2'b01);
                holder = !g;
                if (g) exp_q.push_back(model(1'b1, bus.req1_a, bus.req1_b, bus.req1_op));
                else   exp_q.push_back(model(1'b0, bus.req0_a, bus.req0_b, bus.req0_op));
                acc_cnt++;
                inflight++;
            end
            if (bus.rsp_valid && bus.rsp_ready) inflight--;
        end
    end

    logic       hold = 1'b0;
    logic [2:0] held;
    logic [2:0] e;

    // Response monitor: pops on every handshake, checks stability under stall.
    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold)
                chk("rsp_stable", {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_nv}, {1'b1, held});
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL rsp_unexpected: got id=%0d res=%0d nv=%0d expected no response",
                             bus.rsp_id, bus.rsp_result, bus.rsp_nv);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp", {bus.rsp_id, bus.rsp_result, bus.rsp_nv}, e);
                end
                hold = 1'b0;
            end else if (bus.rsp_valid) begin
                hold = 1'b1;
                held = {bus.rsp_id, bus.rsp_result, bus.rsp_nv};
            end else begin
                hold = 1'b0;
            end
        end
    end

    logic [63:0] specials [10] = '{64'h0000000000000000, 64'h8000000000000000,
                                   64'h3FF0000000000000, 64'h4000000000000000,
                                   64'hBFF0000000000000, 64'h7FF0000000000000,
                                   64'hFFF0000000000000, 64'h7FF8000000000000,
                                   64'h7FF0000000000001, 64'h0000000000000001};

    function automatic logic [63:0] rnd_val();
        if ($urandom_range(0, 2) == 0) return {$urandom, $urandom};
        return specials[$urandom_range(0, 9)];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
        bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    endtask

    task automatic set1(input logic v, input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
        bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    endtask

    task automatic drain();
        set0(1'b0, 64'd0, 64'd0, 2'b00);
        set1(1'b0, 64'd0, 64'd0, 2'b00);
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) step();
        chk("drain_empty", exp_q.size(), 0);
        step();
    endtask

    int start;

    initial begin
        bus.rsp_ready = 1'b1;
        set0(1'b1, 64'h3FF0000000000000, 64'h4000000000000000, 2'b11);
        set1(1'b1, 64'h3FF0000000000000, 64'h4000000000000000, 2'b11);
        step(); step(); step();
        rst = 1'b0;
        set0(1'b0, 64'd0, 64'd0, 2'b00);
        set1(1'b0, 64'd0, 64'd0, 2'b00);
        @(negedge clk);
        chk("reset_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_nv}, 4'b0000);
        chk("reset_cmp_a", bus.cmp_a, 64'd0);
        chk("reset_cmp_b", bus.cmp_b, 64'd0);
        chk("reset_cmp_op", bus.cmp_op, 2'b00);
        step();

        // Basic LT compare and two-cycle latency.
        set0(1'b1, 64'h3FF0000000000000, 64'h4000000000000000, 2'b11);
        @(negedge clk);
        chk("lat_accept", bus.req0_ready, 1'b1);
        step();
        set0(1'b0, 64'd0, 64'd0, 2'b00);
        @(negedge clk);
        chk("lat_t1", bus.rsp_valid, 1'b0);
        step();
        @(negedge clk);
        chk("lat_t2", {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_nv}, 4'b1010);
        drain();

        // Signed-zero equality from requester 1.
        set1(1'b1, 64'h0000000000000000, 64'h8000000000000000, 2'b10);
        step();
        set1(1'b0, 64'd0, 64'd0, 2'b00);
        step();
        @(negedge clk);
        chk("zero_eq", {bus.rsp_valid, bus.rsp_id, bus.rsp_result}, 3'b111);
        drain();

        // Both requesters for four cycles: alternating grants.
        start = acc_cnt;
        set0(1'b1, 64'h4000000000000000, 64'h3FF0000000000000, 2'b00);
        set1(1'b1, 64'h3FF0000000000000, 64'h3FF0000000000000, 2'b10);
        repeat (4) step();
        chk("alt_accepts", acc_cnt - start, 4);
        drain();

        // NaN / illegal op cases.
        set0(1'b1, 64'h7FF8000000000000, 64'h3FF0000000000000, 2'b10); step();
        set0(1'b1, 64'h7FF0000000000001, 64'h3FF0000000000000, 2'b10); step();
        set0(1'b1, 64'h7FF8000000000000, 64'h3FF0000000000000, 2'b00); step();
        set0(1'b1, 64'h3FF0000000000000, 64'h4000000000000000, 2'b01); step();
        drain();

        // Backpressure: exactly two accepts while the consumer stalls.
        start = acc_cnt;
        bus.rsp_ready = 1'b0;
        set0(1'b1, 64'h3FF0000000000000, 64'h4000000000000000, 2'b11);
        set1(1'b1, 64'h4000000000000000, 64'h3FF0000000000000, 2'b00);
        repeat (5) step();
        chk("bp_accepts", acc_cnt - start, 2);
        bus.rsp_ready = 1'b1;
        repeat (3) step();
        drain();

        // Random traffic with random consumer stalls.
        for (int i = 0; i < 400; i++) begin
            set0($urandom_range(0, 1), rnd_val(), rnd_val(), 2'($urandom_range(0, 3)));
            set1($urandom_range(0, 1), rnd_val(), rnd_val(), 2'($urandom_range(0, 3)));
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        // Reset with both stages full.
        bus.rsp_ready = 1'b0;
        set0(1'b1, 64'h3FF0000000000000, 64'h4000000000000000, 2'b11);
        set1(1'b1, 64'h4000000000000000, 64'h3FF0000000000000, 2'b11);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        set0(1'b0, 64'd0, 64'd0, 2'b00);
        set1(1'b0, 64'd0, 64'd0, 2'b00);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("midrst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("midrst_cmp_a", bus.cmp_a, 64'd0);
        step();
        chk("midrst_idle", bus.rsp_valid, 1'b0);
        set0(1'b1, 64'h3FF0000000000000, 64'h3FF0000000000000, 2'b00);
        set1(1'b1, 64'h3FF0000000000000, 64'h3FF0000000000000, 2'b00);
        @(negedge clk);
        chk("midrst_prio", {bus.req1_ready, bus.req0_ready}, PRIO ? 2'b10 : 2'b01);
        for (int i = 0; i < 100; i++) begin
            set0($urandom_range(0, 1), rnd_val(), rnd_val(), 2'($urandom_range(0, 3)));
            set1($urandom_range(0, 1), rnd_val(), rnd_val(), 2'($urandom_range(0, 3)));
            bus.rsp_ready = ($urandom_range(0, 1) != 0);
            step();
        end
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/fp_cmp_arb.md
FP_CMP_ARB -- requirements
Module: fp_cmp_arb

Interface
REQ-001 Parameter: PRIO_RST, default 0, requester index holding priority after reset (0 or 1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1  requester N has a compare pending.
REQ-005 req0_ready / req1_ready  output  1  requester N's operands accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  64  IEEE 754 double operands.
REQ-007 req0_op / req1_op  input  2  10=EQ, 11=LT, 00=LE, 01=illegal.
REQ-008 cmp_a, cmp_b  output  64  operands driven to the shared combinational comparator, from stage-1 register.
REQ-009 cmp_op  output  2  op driven to the shared comparator, from stage-1 register.
REQ-010 cmp_result  input  1  comparator result, valid in the same cycle as cmp_* outputs.
REQ-011 rsp_valid  output  1  response register holds a result.
REQ-012 rsp_ready  input  1  consumer accepts response.
REQ-013 rsp_id  output  1  index of the requester the response belongs to.
REQ-014 rsp_result  output  1  compare result.
REQ-015 rsp_nv  output  1  IEEE invalid-operation flag.

Function
REQ-016 Two stages: S1 operand register (s1_valid, a, b, op, id); S2 response register (rsp_*).
- REQ-017 S2 advance: S2 loads when s1_valid && (!rsp_valid || rsp_ready); otherwise rsp_valid clears on rsp_valid && rsp_ready.
- REQ-018 S1 load: s1_free = !s1_valid || S2 advance.
  - S1 loads the granted request when s1_free and any req valid.
  - Otherwise s1_valid clears when S2 advances.
- REQ-019 Arbitration is round-robin:
  - If only one reqN_valid, grant N.
  - If both valid, grant the priority holder.
  - After any grant, priority moves to the non-granted index.
  - Priority is unchanged when no grant occurs.
- REQ-020 reqN_ready = s1_free && grant==N; it depends combinationally on req*_valid and rsp_ready, never on reqN_ready of the other port; at most one ready per cycle.
- REQ-021 Latency: with no backpressure, a request accepted in cycle T has rsp_valid=1 in cycle T+2.
- REQ-022 Throughput: one accept per cycle sustained while rsp_ready=1.
- REQ-023 rsp_result captures cmp_result.
  - It is forced 0 when S1 op is 01 or when either S1 operand is NaN (exp=0x7FF, mant!=0).
- REQ-024 While rsp_valid && !rsp_ready, all rsp_* outputs hold stable.
  - S1 holds while S2 is blocked.
  - No request is accepted while S1 is full and blocked.
- REQ-025 Simultaneous rsp handshake and S1 load in the same cycle: both take effect, with no bubble and no data loss.
- REQ-026 cmp_a/cmp_b/cmp_op reflect the S1 register contents at all times, including when s1_valid=0.

Reset
REQ-027 On rst=1 at a clock edge:
- s1_valid=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_nv=0, priority=PRIO_RST.
- S1 data registers are cleared to 0.
REQ-028 Reset mid-operation: in-flight S1/S2 contents are discarded without a response, and req*_ready=0 during the reset cycle.

Configuration
REQ-029 Macro FP_CMP_ARB_NV_EN; when defined, rsp_nv is captured with rsp_result:
- EQ: 1 if either operand is a signaling NaN (exp=0x7FF, mant!=0, mant[51]=0).
- LT/LE: 1 if either operand is any NaN.
- Illegal op 01: always 1.
REQ-030 Without FP_CMP_ARB_NV_EN, rsp_nv is constant 0 and no NaN-class logic beyond REQ-023 is built.

Verification
REQ-031 Basic compare:
- Stimulus: req0 LT, a=0x3FF0000000000000 (1.0), b=0x4000000000000000 (2.0), rsp_ready=1, accepted cycle T.
- Response: rsp_valid at T+2, rsp_id=0, rsp_result=1, rsp_nv=0.
REQ-032 Simultaneous requests:
- Stimulus: both valid for 4 cycles after reset, PRIO_RST=0.
- Response: grants 0,1,0,1; responses return in the same order.
REQ-033 Signed-zero equality:
- Stimulus: req1 EQ, a=0x0000000000000000, b=0x8000000000000000.
- Response: rsp_result=1, rsp_id=1.
REQ-034 NaN handling (NV_EN defined):
- EQ with a=0x7FF8000000000000 (qNaN): result=0, nv=0.
- EQ with a=0x7FF0000000000001 (sNaN): result=0, nv=1.
- LE with qNaN: result=0, nv=1.
- op=01: result=0, nv=1.
REQ-035 Backpressure:
- Stimulus: rsp_ready=0 for 5 cycles with both requesters continuously valid.
- Response: exactly two accepts, rsp_* stable, both req*_ready=0 thereafter; after rsp_ready=1, no loss or duplication.
REQ-036 Reset mid-flight:
- Stimulus: assert rst with S1 and S2 full.
- Response: next cycle rsp_valid=0, s1 empty, priority=PRIO_RST, and no stale response appears afterwards.
